// File: rtl/stepperonline_abs_emu.sv
// StepperOnline absolute-encoder responder: answers a 0x7D request with a 7-byte 8N1 frame.
// Latency: acceptance to driver release is TurnCycles + 71 bit times. No backpressure; the receiver is deaf while responding.
module stepperonline_abs_emu #(
   parameter int         ClkFrequency = 32400000,
   parameter int         Baud         = 2500000,
   parameter int         TurnCycles   = ClkFrequency / 100000,
   parameter logic [7:0] ReqByte      = 8'h7D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic [23:0] angle,
   input  logic [7:0]  status,
   input  logic [7:0]  aux,
   output logic        tx,
   output logic        tx_enable,
   output logic        busy,
   output logic [15:0] req_count,
   output logic [7:0]  err_count
);

   localparam int BitCycles = ClkFrequency / Baud;
   localparam int CntMax    = (TurnCycles > BitCycles) ? TurnCycles : BitCycles;
   localparam int CntW      = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] TurnLast = CntW'(TurnCycles - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(BitCycles / 2 - 1);

   typedef enum logic [1:0] {IDLE, TURN, LEAD, SEND} state_t;

   state_t          state, state_nxt;
   logic            rx_meta, rx_sync, rx_prev;
   logic            rx_act;
   logic [3:0]      rbit;
   logic [7:0]      rshift;
   logic [CntW-1:0] cnt;
   logic [3:0]      tbit;
   logic [2:0]      tbyte;
   logic [8:0]      tsh;
   logic [55:0]     frame;
   logic            tx_q;

   logic            fall, rx_sample, stop_sample, accept, rx_err, bit_end, tx_last;
   logic [7:0]      chk;

   assign fall        = rx_prev & ~rx_sync;
   assign rx_sample   = rx_act && (cnt == ((rbit == 4'd0) ? HalfLast : BitLast));
   assign stop_sample = (state == IDLE) && rx_sample && (rbit == 4'd9);
   assign accept      = stop_sample && rx_sync && (rshift == ReqByte);
   assign rx_err      = stop_sample && (!rx_sync || (rshift != ReqByte));
   assign bit_end     = (cnt == BitLast);
   assign tx_last     = (state == SEND) && bit_end && (tbit == 4'd9) && (tbyte == 3'd6);
   assign chk         = ReqByte ^ status ^ angle[7:0] ^ angle[15:8] ^ angle[23:16] ^ aux;

   assign tx        = tx_q;
   assign tx_enable = (state == LEAD) || (state == SEND);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = TURN;
         TURN:    if (cnt == TurnLast) state_nxt = LEAD;
         LEAD:    if (bit_end) state_nxt = SEND;
         SEND:    if (tx_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         rx_act    <= 1'b0;
         rbit      <= '0;
         rshift    <= '0;
         cnt       <= '0;
         tbit      <= '0;
         tbyte     <= '0;
         tsh       <= '1;
         frame     <= '0;
         tx_q      <= 1'b1;
         req_count <= '0;
         err_count <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;

         // One counter serves receive sampling in IDLE and timing in the other states
         if (state_nxt != state)
            cnt <= '0;
         else if (state == IDLE)
            cnt <= (!rx_act || rx_sample) ? '0 : cnt + 1'b1;
         else if (state == TURN)
            cnt <= cnt + 1'b1;
         else
            cnt <= bit_end ? '0 : cnt + 1'b1;

         if (state != IDLE) begin
            rx_act <= 1'b0;
         end else if (!rx_act) begin
            if (fall) begin
               rx_act <= 1'b1;
               rbit   <= 4'd0;
            end
         end else if (rx_sample) begin
            if (rbit == 4'd0) begin
               if (rx_sync) rx_act <= 1'b0;
               else         rbit   <= 4'd1;
            end else if (rbit == 4'd9) begin
               rx_act <= 1'b0;
            end else begin
               rshift <= {rx_sync, rshift[7:1]};
               rbit   <= rbit + 4'd1;
            end
         end

         if (accept)
            req_count <= req_count + 16'd1;
         if (rx_err && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;

         if (accept)
            frame <= {chk, aux, angle[23:16], angle[15:8], angle[7:0], status, ReqByte};

         // tsh holds {stop, data}; the frame buffer shifts out one byte per character
         case (state)
            LEAD: begin
               if (bit_end) begin
                  tsh   <= {1'b1, frame[7:0]};
                  frame <= frame >> 8;
                  tbit  <= 4'd0;
                  tbyte <= 3'd0;
                  tx_q  <= 1'b0;
               end else begin
                  tx_q <= 1'b1;
               end
            end
            SEND: begin
               if (bit_end) begin
                  if (tbit == 4'd9) begin
                     if (tbyte != 3'd6) begin
                        tsh   <= {1'b1, frame[7:0]};
                        frame <= frame >> 8;
                        tbit  <= 4'd0;
                        tbyte <= tbyte + 3'd1;
                        tx_q  <= 1'b0;
                     end else begin
                        tx_q <= 1'b1;
                     end
                  end else begin
                     tx_q <= tsh[0];
                     tsh  <= tsh >> 1;
                     tbit <= tbit + 4'd1;
                  end
               end
            end
            default: tx_q <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_stepperonline_abs_emu.sv
// Directed bench for stepperonline_abs_emu: drives 8N1 requests and decodes the response frame.
module tb_stepperonline_abs_emu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic [23:0] angle = 24'h012345;
   logic [7:0]  status = 8'hA5;
   logic [7:0]  aux = 8'h3C;
   logic        tx, tx_enable, busy;
   logic [15:0] req_count;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stepperonline_abs_emu dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .angle     (angle),
      .status    (status),
      .aux       (aux),
      .tx        (tx),
      .tx_enable (tx_enable),
      .busy      (busy),
      .req_count (req_count),
      .err_count (err_count)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (12) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (12) @(negedge clk);
      end
      rx = stop;
      repeat (12) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Waits (bounded) for tx_enable, then samples every bit at mid-cell relative to the enable edge
   task automatic get_frame(input int bound, output logic [55:0] data, output bit frm_ok,
                            output int wait_len, output int en_len, output bit got);
      int n;
      logic [69:0] bits;
      data = '0; frm_ok = 1'b1; wait_len = 0; en_len = 0; got = 1'b0; bits = '1;
      n = 0;
      while (!tx_enable && n < bound) begin
         @(negedge clk);
         n++;
      end
      wait_len = n;
      if (!tx_enable) return;
      got = 1'b1;
      n = 0;
      while (tx_enable && n < 2000) begin
         if (n >= 18 && (n - 18) % 12 == 0 && (n - 18) / 12 < 70) bits[(n - 18) / 12] = tx;
         @(negedge clk);
         n++;
      end
      en_len = n;
      for (int b = 0; b < 7; b++) begin
         if (bits[b*10] !== 1'b0 || bits[b*10+9] !== 1'b1) frm_ok = 1'b0;
         data[b*8 +: 8] = bits[b*10+1 +: 8];
      end
   endtask

   logic [55:0] fd;
   bit          fok, got;
   int          wl, el;

   initial begin
      // reset state
      @(negedge clk);
      check_val("rst_tx", tx, 1'b1);
      check_val("rst_tx_enable", tx_enable, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_req_count", req_count, 16'h0000);
      check_val("rst_err_count", err_count, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // basic request
      send_byte(8'h7D, 1'b1);
      check_val("t1_busy_during", busy, 1'b1);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t1_got", got, 1'b1);
      check_val("t1_frame", fd, 56'h833C012345A57D);
      check_val("t1_framing", fok, 1'b1);
      check_val("t1_turnaround", wl, 321);
      check_val("t1_enable_len", el, 852);
      check_val("t1_busy_after", busy, 1'b0);
      check_val("t1_tx_idle", tx, 1'b1);
      check_val("t1_req_count", req_count, 16'h0001);
      check_val("t1_err_count", err_count, 8'h00);

      // rejected byte
      do_reset();
      send_byte(8'h32, 1'b1);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t2_no_frame", got, 1'b0);
      check_val("t2_err_count", err_count, 8'h01);
      check_val("t2_req_count", req_count, 16'h0000);

      // start-bit glitch is ignored
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      check_val("glitch_err_count", err_count, 8'h01);
      check_val("glitch_busy", busy, 1'b0);

      // framing error then valid request
      do_reset();
      send_byte(8'h7D, 1'b0);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t3_no_frame", got, 1'b0);
      check_val("t3_err_count", err_count, 8'h01);
      send_byte(8'h7D, 1'b1);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t3_got", got, 1'b1);
      check_val("t3_frame", fd, 56'h833C012345A57D);
      check_val("t3_req_count", req_count, 16'h0001);

      // inputs change mid-frame; next request reflects new angle
      do_reset();
      send_byte(8'h7D, 1'b1);
      fork
         get_frame(1500, fd, fok, wl, el, got);
         begin
            for (int i = 0; i < 1500 && !tx_enable; i++) @(negedge clk);
            repeat (300) @(negedge clk);
            angle = 24'hFFFFFF;
         end
      join
      check_val("t4_frame_latched", fd, 56'h833C012345A57D);
      send_byte(8'h7D, 1'b1);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t4_frame_new", fd, 56'h1B3CFFFFFFA57D);
      check_val("t4_framing", fok, 1'b1);
      check_val("t4_req_count", req_count, 16'h0002);
      angle = 24'h012345;

      // bytes during TURN and SEND are ignored
      do_reset();
      send_byte(8'h7D, 1'b1);
      fork
         get_frame(1500, fd, fok, wl, el, got);
         begin
            send_byte(8'h7D, 1'b1);
            for (int i = 0; i < 1500 && !tx_enable; i++) @(negedge clk);
            repeat (200) @(negedge clk);
            send_byte(8'h7D, 1'b1);
         end
      join
      check_val("t5_frame", fd, 56'h833C012345A57D);
      check_val("t5_enable_len", el, 852);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t5_no_second_frame", got, 1'b0);
      check_val("t5_req_count", req_count, 16'h0001);
      check_val("t5_err_count", err_count, 8'h00);

      // async reset mid-B3 start bit
      do_reset();
      send_byte(8'h7D, 1'b1);
      for (int i = 0; i < 1500 && !tx_enable; i++) @(negedge clk);
      repeat (378) @(negedge clk);
      check_val("t6_tx_b3_start", tx, 1'b0);
      check_val("t6_enable_pre", tx_enable, 1'b1);
      rst = 1'b1;
      #1;
      check_val("t6_tx_reset", tx, 1'b1);
      check_val("t6_enable_reset", tx_enable, 1'b0);
      check_val("t6_busy_reset", busy, 1'b0);
      check_val("t6_req_reset", req_count, 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send_byte(8'h7D, 1'b1);
      get_frame(1500, fd, fok, wl, el, got);
      check_val("t6_frame", fd, 56'h833C012345A57D);
      check_val("t6_framing", fok, 1'b1);
      check_val("t6_req_count", req_count, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
